// File: rtl/uart_rx.sv
// 8N1 UART receiver: free-running oversample tick, mid-bit sampling, one-cycle result pulses.
// Optional even parity (8E1) is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int TICK_DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_error,
   output logic       parity_error,
   output logic       busy,
   output logic [2:0] dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
      S_PARITY = 3'd5,
`endif
      S_BREAK  = 3'd4
   } state_e;

   localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
   localparam logic [3:0]  S_MID     = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0]  S_LAST    = 4'(OVERSAMPLE - 1);

   logic        sync1_q;
   logic        rx_s_q;
   logic [15:0] tcnt_q, tcnt_d;
   logic        tick;
   state_e      state_q, state_d;
   logic [3:0]  scnt_q, scnt_d;
   logic [2:0]  bidx_q, bidx_d;
   logic [7:0]  sr_q, sr_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
   logic        par_pend_q, par_pend_d;
   logic        par_err_q, par_err_d;
`endif

   // Tick grid is never re-phased; a start edge is resolved to within one tick.
   assign tick   = (tcnt_q == TICK_LAST);
   assign tcnt_d = tick ? 16'd0 : tcnt_q + 16'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b1;
         rx_s_q      <= 1'b1;
         tcnt_q      <= 16'd0;
         state_q     <= S_IDLE;
         scnt_q      <= 4'd0;
         bidx_q      <= 3'd0;
         sr_q        <= 8'h00;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_pend_q  <= 1'b0;
         par_err_q   <= 1'b0;
`endif
      end else begin
         sync1_q     <= rx;
         rx_s_q      <= sync1_q;
         tcnt_q      <= tcnt_d;
         state_q     <= state_d;
         scnt_q      <= scnt_d;
         bidx_q      <= bidx_d;
         sr_q        <= sr_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
         par_pend_q  <= par_pend_d;
         par_err_q   <= par_err_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      scnt_d      = scnt_q;
      bidx_d      = bidx_q;
      sr_d        = sr_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_pend_d  = par_pend_q;
      par_err_d   = 1'b0;
`endif
      if (tick) begin
         case (state_q)
            S_IDLE: begin
               if (!rx_s_q) begin
                  state_d = S_START;
                  scnt_d  = 4'd0;
               end
            end
            S_START: begin
               if (scnt_q == S_MID) begin
                  scnt_d = 4'd0;
                  if (!rx_s_q) begin
                     state_d    = S_DATA;
                     bidx_d     = 3'd0;
`ifdef UART_RX_PARITY_EN
                     par_pend_d = 1'b0;
`endif
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  scnt_d = scnt_q + 4'd1;
               end
            end
            S_DATA: begin
               if (scnt_q == S_LAST) begin
                  sr_d   = {rx_s_q, sr_q[7:1]};
                  scnt_d = 4'd0;
                  bidx_d = bidx_q + 3'd1;
                  if (bidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_d = S_PARITY;
`else
                     state_d = S_STOP;
`endif
                  end
               end else begin
                  scnt_d = scnt_q + 4'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (scnt_q == S_LAST) begin
                  par_pend_d = (^sr_q) ^ rx_s_q;
                  scnt_d     = 4'd0;
                  state_d    = S_STOP;
               end else begin
                  scnt_d = scnt_q + 4'd1;
               end
            end
`endif
            S_STOP: begin
               if (scnt_q == S_LAST) begin
                  scnt_d = 4'd0;
                  if (rx_s_q) begin
                     state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                     if (par_pend_q) begin
                        par_err_d = 1'b1;
                     end else begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = sr_q;
                     end
`else
                     rx_valid_d = 1'b1;
                     rx_data_d  = sr_q;
`endif
                  end else begin
                     // Bad stop wins over any pending parity mismatch.
                     frame_err_d = 1'b1;
                     state_d     = S_BREAK;
                  end
               end else begin
                  scnt_d = scnt_q + 4'd1;
               end
            end
            S_BREAK: begin
               if (rx_s_q) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign frame_error = frame_err_q;
`ifdef UART_RX_PARITY_EN
   assign parity_error = par_err_q;
`else
   assign parity_error = 1'b0;
`endif
   assign busy        = (state_q != S_IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random frames against a frame-level model.
module tb_uart_rx;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int OVS      = 16;
  localparam int BIT_CLK  = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int STOP_MID = (FRAME_BITS - 1) * BIT_CLK + BIT_CLK / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       parity_error;
  logic       busy;
  logic [2:0] dbg_state;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD),
    .OVERSAMPLE(OVS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_error (frame_error),
    .parity_error(parity_error),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {kind, data}; kind 0 = valid, 1 = frame error, 2 = parity error
  logic [9:0] exp_q[$];
  int         pulse_t[$];
  logic [7:0] last_good = 8'h00;
  logic       prev_pulse = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         t_edge = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    logic [1:0] kind;
    logic [9:0] e;
    logic       any;
    any = rst_n && (rx_valid || frame_error || parity_error);
    if (any) begin
      kind = rx_valid ? 2'd0 : (frame_error ? 2'd1 : 2'd2);
      check("pulse_excl", int'(rx_valid) + int'(frame_error) + int'(parity_error), 1);
      check("pulse_gap", prev_pulse, 0);
      pulse_t.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("spurious_kind", kind, 32'hF);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", kind, e[9:8]);
        if (e[9:8] == 2'd0) begin
          check("rx_data", rx_data, e[7:0]);
          last_good = e[7:0];
        end else begin
          check("rx_data_hold", rx_data, last_good);
        end
      end
    end
    prev_pulse = any;
  end

  // drivers
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_bad);
    if (!stop_ok) exp_q.push_back({2'd1, d});
`ifdef UART_RX_PARITY_EN
    else if (par_bad) exp_q.push_back({2'd2, d});
`endif
    else exp_q.push_back({2'd0, d});
    t_edge = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_bad);
`endif
    drive_bit(stop_ok);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int gap;
    logic [7:0] d;
    logic so;
    logic pb;

    // reset state
    repeat (5) @(negedge clk);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_error", frame_error, 0);
    check("rst_parity_error", parity_error, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(2 * BIT_CLK);

    // single frame and start-to-valid latency
    pulse_t.delete();
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(BIT_CLK);
    wait_drain("drain_a5");
    lat = (pulse_t.size() == 1) ? pulse_t[0] - t_edge : -1;
    check("lat_a5_in_range", (lat >= STOP_MID + 2 && lat <= STOP_MID + 13), 1);
    check("busy_after_a5", busy, 0);
    check("data_a5", rx_data, 8'hA5);

    // back-to-back frames, no idle gap
    pulse_t.delete();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(BIT_CLK);
    wait_drain("drain_b2b");
    check("b2b_count", pulse_t.size(), 2);
    gap = (pulse_t.size() >= 2) ? pulse_t[1] - pulse_t[0] : 0;
    check("b2b_gap", gap, FRAME_BITS * BIT_CLK);
    check("data_ff", rx_data, 8'hFF);

    // 40-clk glitch on idle line
    rx = 1'b0;
    repeat (30) @(negedge clk);
    check("glitch_busy_high", busy, 1);
    repeat (10) @(negedge clk);
    idle(BIT_CLK);
    check("glitch_busy_low", busy, 0);
    check("glitch_data_kept", rx_data, 8'hFF);

    // bad stop followed by a held-low break
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (5 * BIT_CLK) @(negedge clk);
    idle(BIT_CLK);
    wait_drain("drain_fe");
    check("fe_data_kept", rx_data, 8'hFF);
    check("fe_busy_low", busy, 0);
    send_frame(8'h55, 1'b1, 1'b0);
    idle(BIT_CLK);
    wait_drain("drain_55");
    check("data_55", rx_data, 8'h55);

    // reset in the middle of a frame
    d = 8'h81;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_data", rx_data, 8'h00);
    check("midrst_busy", busy, 0);
    last_good = 8'h00;
    rst_n = 1'b1;
    idle(BIT_CLK);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(BIT_CLK);
    wait_drain("drain_7e");
    check("data_7e", rx_data, 8'h7E);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    idle(BIT_CLK);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(BIT_CLK);
    wait_drain("drain_parity");
    check("parity_data_kept", rx_data, 8'h07);
`endif

    // random frames with random gaps
    for (int k = 0; k < 16; k++) begin
      d  = 8'($urandom_range(0, 255));
      so = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
      pb = ($urandom_range(0, 3) == 0);
`else
      pb = 1'b0;
`endif
      send_frame(d, so, pb);
      if (!so) gap = $urandom_range(BIT_CLK, 3 * BIT_CLK);
      else if ($urandom_range(0, 1) == 0) gap = 0;
      else gap = $urandom_range(1, 400);
      idle(gap);
    end
    idle(2 * BIT_CLK);
    wait_drain("drain_rand");
    check("rand_busy_low", busy, 0);
    check("rand_data_final", rx_data, last_good);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for 8N1 serial frames. It is the receive-side counterpart of the baud-enable generator feeding the transmit path.
- Internally it generates its own oversampling tick at OVERSAMPLE x BAUD_RATE and samples each bit at mid-bit.
- It outputs each received byte with a one-cycle valid pulse to the downstream logic.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: serial bit rate in bit/s.
- OVERSAMPLE, 16: ticks per bit. Must be an even number >= 4.
- TICK_DIV, CLK_FREQ/(BAUD_RATE*OVERSAMPLE): clocks per oversample tick, integer-truncated (325 at defaults).

Ports:
- clk  input  1  system clock, all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  asynchronous serial line, idle high.
- rx_data  output  8  last correctly received byte.
- rx_valid  output  1  one-cycle pulse; rx_data is updated in the same cycle.
- frame_error  output  1  one-cycle pulse when the stop bit is sampled low.
- parity_error  output  1  one-cycle pulse on parity mismatch. Tied 0 when UART_RX_PARITY_EN is undefined.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: rx_data=8'h00; rx_valid, frame_error, parity_error, busy all 0; state=IDLE; synchronizer flops=1; all counters 0.
- Synchronizer: rx passes through 2 flops (rx_s). Only rx_s is used internally.
- Tick generator:
  - Free-running 16-bit counter. It wraps at TICK_DIV-1 and asserts tick for one clk.
  - It runs continuously from reset and is never re-phased on a start edge.
  - Start-edge uncertainty is 1 tick, which is acceptable.
- Per-state 4-bit sample counter scnt; 3-bit bit index bidx; 8-bit shift register sr (LSB first). State and counters change only on cycles where tick=1.
- IDLE:
  - tick & rx_s==0 -> START, scnt=0.
- START:
  - On tick, scnt++.
  - When scnt reaches OVERSAMPLE/2-1, check rx_s:
    - rx_s==0 -> DATA, scnt=0, bidx=0.
    - rx_s==1 -> glitch: IDLE, no outputs pulsed.
- DATA:
  - On tick, scnt++.
  - At scnt==OVERSAMPLE-1: sr={rx_s, sr[7:1]}, scnt=0, bidx++.
  - After the 8th bit (bidx==7 at sample): -> PARITY if the macro is defined, else STOP.
- STOP:
  - Sample at scnt==OVERSAMPLE-1.
  - rx_s==1: rx_data<=sr, rx_valid=1 for one clk, -> IDLE. Under the macro, rx_valid is suppressed when a parity error is pending; parity_error pulses instead and rx_data is not updated.
  - rx_s==0: frame_error=1 for one clk, rx_data unchanged, -> BREAK.
- BREAK:
  - Remain until tick & rx_s==1, then -> IDLE.
  - A held-low line (break) therefore yields exactly one frame_error and no spurious frames.
- Latency: rx_valid asserts 1 clk after the tick that samples mid-stop-bit, about 9.5 bit times after the start edge plus a 2-3 clk synchronizer delay.
- rx_valid, frame_error and parity_error are mutually exclusive and never high in consecutive clocks.
- A new start bit is accepted on the first tick in IDLE after the stop sample. Back-to-back frames with no idle gap are received without loss.
- Reset asserted mid-frame: immediate return to reset values. The partial byte is discarded and no pulse is issued.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. State PARITY follows DATA and samples the parity bit at scnt==OVERSAMPLE-1.
  - Mismatch when (^sr) ^ parity_bit != 0; the mismatch is latched.
  - At the stop sample, a valid stop with a latched mismatch gives a parity_error pulse instead of rx_valid.
  - A bad stop bit gives frame_error only; it takes priority over parity_error.
- Undefined:
  - PARITY state is not compiled; parity_error is constant 0; frame is 8N1.

Test Plan:
- Bench parameters: CLK_FREQ=1_600_000, BAUD_RATE=10_000 (TICK_DIV=10, 160 clk/bit).
- Send 8'hA5 as an 8N1 frame from idle -> one rx_valid pulse, rx_data=8'hA5, frame_error=0, busy low afterwards.
- Send 8'h00 then 8'hFF back-to-back with zero idle gap -> two rx_valid pulses about 1600 clk apart; rx_data reads 8'h00 then 8'hFF.
- Drive a 40-clk low glitch on an idle rx -> no rx_valid, no frame_error, state returns to IDLE, busy drops within one bit time.
- Send 8'h3C with the stop bit driven low, then hold rx low for 5 bit times, then release high -> exactly one frame_error pulse, rx_data retains its previous value, next 8'h55 frame received correctly.
- Assert rst_n=0 after 4 data bits of 8'h81, release, then send 8'h7E -> no pulse for the aborted frame; one rx_valid with rx_data=8'h7E.
- With UART_RX_PARITY_EN: send 8'h07 with parity bit 1 (correct, even) -> rx_valid with rx_data=8'h07. Send 8'h07 with parity bit 0 -> parity_error pulse, no rx_valid, rx_data unchanged.
